// File: rtl/uart_io_pkg.sv
// Shared definitions for the UART I/O controller: default register addresses,
// STATUS/CTRL bit positions and the transmit state encoding.
package uart_io_pkg;

    localparam logic [15:0] TXDATA_ADDR_DEF = 16'h00F0;
    localparam logic [15:0] RXDATA_ADDR_DEF = 16'h00F1;
    localparam logic [15:0] STATUS_ADDR_DEF = 16'h00F2;
    localparam logic [15:0] CTRL_ADDR_DEF   = 16'h00F3;

    localparam int ST_RX_FULL    = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_RX_ERR     = 3;
    localparam int ST_TX_TIMEOUT = 4;
    localparam int ST_TX_DROP    = 5;
    localparam int ST_TX_BUSY    = 6;

    localparam int CTRL_RX_EN = 0;
    localparam int CTRL_TX_EN = 1;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_REQ  = 2'd1,
        T_BUSY = 2'd2
    } tx_state_t;

    // A set event in the same cycle as a write-1-to-clear keeps the flag set.
    function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
        return set | (cur & ~clr);
    endfunction

endpackage

// File: rtl/uart_io_ctrl_if.sv
// CPU-side register bus of the UART I/O controller.
interface uart_io_ctrl_if;
    // cpu_we / cpu_re are one-cycle strobes qualified by cpu_addr; the slave
    // accepts every strobe (ready is implicitly 1) and cpu_rdata is combinational.
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [15:0] cpu_rdata;

    modport master (output cpu_addr, output cpu_wdata, output cpu_we, output cpu_re,
                    input  cpu_rdata);
    modport slave  (input  cpu_addr, input  cpu_wdata, input  cpu_we, input  cpu_re,
                    output cpu_rdata);
endinterface

// File: rtl/uart_io_ctrl_bit_sync.sv
// Two-flop synchronizer for a single level crossing into the clk domain.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_io_ctrl.sv
// UART I/O controller: memory-mapped TX/RX holding registers, STATUS and CTRL
// for the CPU bus, with synchronized handshakes towards the UART core.
module uart_io_ctrl
    import uart_io_pkg::*;
#(
    parameter logic [15:0] TXDATA_ADDR = TXDATA_ADDR_DEF,
    parameter logic [15:0] RXDATA_ADDR = RXDATA_ADDR_DEF,
    parameter logic [15:0] STATUS_ADDR = STATUS_ADDR_DEF,
    parameter logic [15:0] CTRL_ADDR   = CTRL_ADDR_DEF,
    parameter int unsigned ACK_TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rst,
    uart_io_ctrl_if.slave bus,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          rx_error,
    input  logic          tx_idle,
    output logic [7:0]    tx_data,
    output logic          tx_req,
    output tx_state_t     dbg_state
);
    localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(ACK_TIMEOUT);

    logic          rx_valid_s, rx_error_s, tx_idle_s;
    logic          rx_valid_d, rx_error_d;
    logic          rx_new, err_rise;
    logic          wr_tx, wr_st, wr_ctrl, rd_rx;
    logic [7:0]    rx_buf, tx_buf;
    logic          rx_full, tx_full, rx_overrun, rx_err, tx_timeout, tx_drop;
    logic [1:0]    ctrl;
    logic [CW-1:0] cnt, cnt_inc;
    tx_state_t     state, state_nxt;
    logic          start_tx, ack, tmo;
    logic [15:0]   status_word;
    logic          unused_wdata_hi;

    bit_sync u_sync_rx_valid (.clk(clk), .rst(rst), .d(rx_valid), .q(rx_valid_s));
    bit_sync u_sync_rx_error (.clk(clk), .rst(rst), .d(rx_error), .q(rx_error_s));
    bit_sync u_sync_tx_idle  (.clk(clk), .rst(rst), .d(tx_idle),  .q(tx_idle_s));

    assign rx_new   = rx_valid_s & ~rx_valid_d & ctrl[CTRL_RX_EN];
    assign err_rise = rx_error_s & ~rx_error_d;
    assign wr_tx    = bus.cpu_we && (bus.cpu_addr == TXDATA_ADDR);
    assign wr_st    = bus.cpu_we && (bus.cpu_addr == STATUS_ADDR);
    assign wr_ctrl  = bus.cpu_we && (bus.cpu_addr == CTRL_ADDR);
    assign rd_rx    = bus.cpu_re && (bus.cpu_addr == RXDATA_ADDR);

    assign tx_req          = (state == T_REQ);
    assign dbg_state       = state;
    assign unused_wdata_hi = ^bus.cpu_wdata[15:8];

    // The acknowledge timer saturates at the limit; reaching it ends the request.
    always_comb begin
        state_nxt = state;
        start_tx  = 1'b0;
        ack       = 1'b0;
        tmo       = 1'b0;
        cnt_inc   = (cnt == TMO) ? cnt : cnt + CW'(1);
        case (state)
            T_IDLE: if (tx_full && ctrl[CTRL_TX_EN]) begin
                state_nxt = T_REQ;
                start_tx  = 1'b1;
            end
            T_REQ: if (!tx_idle_s) begin
                state_nxt = T_BUSY;
                ack       = 1'b1;
            end else if (cnt_inc == TMO) begin
                state_nxt = T_IDLE;
                tmo       = 1'b1;
            end
            T_BUSY: if (tx_idle_s) state_nxt = T_IDLE;
            default: state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= T_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_d <= 1'b0;
            rx_error_d <= 1'b0;
            cnt        <= '0;
            tx_data    <= 8'h00;
            rx_buf     <= 8'h00;
            tx_buf     <= 8'h00;
            rx_full    <= 1'b0;
            tx_full    <= 1'b0;
            rx_overrun <= 1'b0;
            rx_err     <= 1'b0;
            tx_timeout <= 1'b0;
            tx_drop    <= 1'b0;
            ctrl       <= 2'b11;
        end else begin
            rx_valid_d <= rx_valid_s;
            rx_error_d <= rx_error_s;

            if (start_tx) begin
                tx_data <= tx_buf;
                cnt     <= '0;
            end else if (state == T_REQ) begin
                cnt <= cnt_inc;
            end

            // A read that consumes the buffer makes room for a byte landing the same cycle.
            if (rx_new && (!rx_full || rd_rx)) begin
                rx_buf  <= rx_data;
                rx_full <= 1'b1;
            end else if (rd_rx) begin
                rx_full <= 1'b0;
            end

            if (wr_tx && !tx_full) begin
                tx_buf  <= bus.cpu_wdata[7:0];
                tx_full <= 1'b1;
            end else if (ack || tmo) begin
                tx_full <= 1'b0;
            end

            rx_overrun <= sticky_next(rx_overrun, rx_new && rx_full && !rd_rx,
                                      wr_st && bus.cpu_wdata[ST_RX_OVERRUN]);
            rx_err     <= sticky_next(rx_err, err_rise, wr_st && bus.cpu_wdata[ST_RX_ERR]);
            tx_timeout <= sticky_next(tx_timeout, tmo, wr_st && bus.cpu_wdata[ST_TX_TIMEOUT]);
            tx_drop    <= sticky_next(tx_drop, wr_tx && tx_full,
                                      wr_st && bus.cpu_wdata[ST_TX_DROP]);

            if (wr_ctrl) ctrl <= bus.cpu_wdata[1:0];
        end
    end

    always_comb begin
        status_word                = '0;
        status_word[ST_RX_FULL]    = rx_full;
        status_word[ST_TX_FULL]    = tx_full;
        status_word[ST_RX_OVERRUN] = rx_overrun;
        status_word[ST_RX_ERR]     = rx_err;
        status_word[ST_TX_TIMEOUT] = tx_timeout;
        status_word[ST_TX_DROP]    = tx_drop;
        status_word[ST_TX_BUSY]    = (state != T_IDLE);
    end

    always_comb begin
        bus.cpu_rdata = '0;
        if (bus.cpu_addr == TXDATA_ADDR)      bus.cpu_rdata = {8'h00, tx_buf};
        else if (bus.cpu_addr == RXDATA_ADDR) bus.cpu_rdata = {8'h00, rx_buf};
        else if (bus.cpu_addr == STATUS_ADDR) bus.cpu_rdata = status_word;
        else if (bus.cpu_addr == CTRL_ADDR)   bus.cpu_rdata = {14'b0, ctrl};
    end
endmodule
